pwm_capture_wrapper: RTL and testbench
======================================

Name: pwm_capture_wrapper

Overview:
- Bus-readable PWM input capture: measures high time and period of CapWidth external PWM-style inputs, one capture channel per input.
- Receiving counterpart of the PWM output wrapper. Sits on the device bus as a responder, using the same request/rvalid protocol and 10-bit local address decode.
- Software reads the latest measurement per channel and clears status flags by writing.

Parameters:
- CapWidth, 4, number of capture channels (1..32).
- CapCtrSize, 16, measurement counter width in bits (1..29).
- BusAddrWidth, 32, device bus address width.
- BusDataWidth, 32, device bus data width.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- device_req_i  input  1  bus request.
- device_addr_i  input  BusAddrWidth  byte address; only bits [9:0] are decoded.
- device_we_i  input  1  1 = write, 0 = read.
- device_be_i  input  4  byte enables; ignored, full-word access only.
- device_wdata_i  input  BusDataWidth  write data.
- device_rvalid_o  output  1  response valid, one cycle after the request.
- device_rdata_o  output  BusDataWidth  read data, valid while rvalid is high.
- pwm_i  input  CapWidth  asynchronous PWM inputs, one bit per channel.

Behaviour:
- Reset: every flop clears to 0, including sync stages, counters, captures, valid, overflow, armed, device_rvalid_o and device_rdata_o.
- Input synchronisation, per channel:
  - 2-flop synchroniser produces s; a third flop holds prev.
  - rise = s & ~prev; fall = ~s & prev.
  - A pin transition is therefore acted on at the 3rd clock edge after it.
- Counter cnt (CapCtrSize bits), per channel:
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt + 1, saturating at all-ones (no wrap).
  - cnt equals cycles elapsed since the last rise.
- Fall: hi_tmp <= cnt, giving the high time in cycles.
- Rise when armed = 1:
  - period_q <= cnt; high_q <= hi_tmp; valid <= 1.
  - If cnt is all-ones: overflow <= 1, and period_q holds the saturated value.
- Rise when armed = 0: armed <= 1 only; nothing is captured. The first full period after reset therefore completes at the second rise.
- Stalled input: cnt saturated while armed = 1 and no edge → overflow <= 1 (sticky). valid, period_q and high_q are unchanged.
- Register map:
  - Channel index = addr[9:3]; addr[2] selects the word; addr[1:0] is ignored.
  - Word 0 (addr[2] = 0): bit 31 = valid, bit 30 = overflow, bits [CapCtrSize-1:0] = high_q, all other bits 0.
  - Word 1 (addr[2] = 1): bits [CapCtrSize-1:0] = period_q, all other bits 0.
  - Index >= CapWidth: reads return 0, writes have no effect.
- Writes:
  - Write to word 0 with wdata[0] = 1 clears valid and overflow (W1C).
  - Writes to word 1, and word-0 writes with wdata[0] = 0, have no effect.
  - If a capture or overflow set occurs in the same cycle as a clear, the set wins for that flag. A flag not being set that cycle is cleared.
- Bus timing:
  - device_rvalid_o <= device_req_i every cycle, for both reads and writes.
  - device_rdata_o is registered. Next cycle it holds the read data for a read request, and 0 for a write request or no request.
  - Read data reflects register state before any update in the request cycle.
  - Back-to-back requests are accepted every cycle; no stalls.
- Reset mid-measurement: everything clears and armed = 0, so the next rise only re-arms.
- Constant input (stuck 0 or stuck 1) produces no capture; overflow sets once cnt saturates after arming.

Test Plan:
- Reset, then read word 0 and word 1 of channel 0 → rvalid high exactly one cycle after req, rdata = 0 for both.
- Drive ch0 with period 100 cycles, high 25 cycles, for 3 periods. Then read addr 0x000 → 0x8000_0019; read addr 0x004 → 0x0000_0064.
- Drive ch2 with period 40 and high 10, and ch3 with period 60 and high 30, concurrently. Then read addr 0x010 → 0x8000_000A; 0x014 → 0x28; 0x018 → 0x8000_001E; 0x01C → 0x3C. Channels must show no crosstalk.
- CapCtrSize = 8: one rise, one fall, then hold low for 300 cycles → word 0 bit 30 = 1, bit 31 = 0. On the next rise → period_q = 0xFF, valid = 1.
- After a valid capture, write 0x1 to addr 0x000 → word 0 bits 31:30 = 0; high_q and period_q are retained. Issue the write in the same cycle as a capture rise → valid remains 1.
- Read addr 0x3F8 (index 127, beyond CapWidth) → rdata = 0 with rvalid asserted. Write to it → no channel changes.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Device bus responder interface for the PWM capture block.
// Request/rvalid protocol: one request per cycle, response exactly one cycle later.
interface pwm_capture_if #(
  parameter int BusAddrWidth = 32,
  parameter int BusDataWidth = 32
);
  logic                    device_req_i;
  logic [BusAddrWidth-1:0] device_addr_i;
  logic                    device_we_i;
  logic [3:0]              device_be_i;
  logic [BusDataWidth-1:0] device_wdata_i;
  logic                    device_rvalid_o;
  logic [BusDataWidth-1:0] device_rdata_o;

  modport master (
    output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    input  device_rvalid_o, device_rdata_o
  );

  modport slave (
    input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    output device_rvalid_o, device_rdata_o
  );
endinterface

// File: rtl/pwm_capture_wrapper.sv
// Bus-readable PWM input capture. Each channel measures high time and period
// in clk_i cycles between rising edges of its synchronised input.
//
// Register map (per channel, index = addr[9:3]):
//   word 0 : [31] valid, [30] overflow, [CapCtrSize-1:0] high time  (write bit0=1 clears flags)
//   word 1 : [CapCtrSize-1:0] period
module pwm_capture_wrapper #(
  parameter int CapWidth     = 4,
  parameter int CapCtrSize   = 16,
  parameter int BusAddrWidth = 32,
  parameter int BusDataWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  pwm_capture_if.slave        bus,
  input  logic [CapWidth-1:0] pwm_i
);

  localparam logic [CapCtrSize-1:0] CntMax = '1;
  localparam logic [CapCtrSize-1:0] CntOne = CapCtrSize'(1);

  logic [CapWidth-1:0] sync1_q, sync1_d;
  logic [CapWidth-1:0] sync2_q, sync2_d;
  logic [CapWidth-1:0] prev_q, prev_d;
  logic [CapWidth-1:0] armed_q, armed_d;
  logic [CapWidth-1:0] valid_q, valid_d;
  logic [CapWidth-1:0] ovf_q, ovf_d;

  logic [CapWidth-1:0][CapCtrSize-1:0] cnt_q, cnt_d;
  logic [CapWidth-1:0][CapCtrSize-1:0] hi_tmp_q, hi_tmp_d;
  logic [CapWidth-1:0][CapCtrSize-1:0] high_q, high_d;
  logic [CapWidth-1:0][CapCtrSize-1:0] period_q, period_d;

  logic                    rvalid_q, rvalid_d;
  logic [BusDataWidth-1:0] rdata_q, rdata_d;

  logic [CapWidth-1:0] rise, fall, sat;
  logic [CapWidth-1:0] chan_hit, clr;
  logic [CapWidth-1:0] set_valid, set_ovf;
  logic [6:0]          idx;
  logic                word_sel;
  logic [BusDataWidth-1:0] rd_word;

  assign idx      = bus.device_addr_i[9:3];
  assign word_sel = bus.device_addr_i[2];
  assign rise     = sync2_q & ~prev_q;
  assign fall     = ~sync2_q & prev_q;

  // Byte enables, upper address bits and the rest of wdata carry no meaning here.
  logic unused_bus;
  assign unused_bus = ^{bus.device_be_i, bus.device_addr_i[BusAddrWidth-1:10],
                        bus.device_addr_i[1:0], bus.device_wdata_i[BusDataWidth-1:1]};

  // Address decode: which channel (if any) the request targets, and W1C strobes.
  always_comb begin
    chan_hit = '0;
    clr      = '0;
    sat      = '0;
    for (int c = 0; c < CapWidth; c++) begin
      chan_hit[c] = (idx == 7'(c));
      clr[c]      = bus.device_req_i & bus.device_we_i & ~word_sel &
                    bus.device_wdata_i[0] & chan_hit[c];
      sat[c]      = (cnt_q[c] == CntMax);
    end
  end

  // Per-channel synchroniser, edge counter and capture logic.
  always_comb begin
    sync1_d   = pwm_i;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    hi_tmp_d  = hi_tmp_q;
    high_d    = high_q;
    period_d  = period_q;
    set_valid = '0;
    set_ovf   = '0;
    for (int c = 0; c < CapWidth; c++) begin
      if (rise[c])     cnt_d[c] = CntOne;
      else if (!sat[c]) cnt_d[c] = cnt_q[c] + CntOne;

      if (fall[c]) hi_tmp_d[c] = cnt_q[c];

      if (rise[c]) begin
        if (armed_q[c]) begin
          // The first rise after reset only arms; a full period needs two rises.
          period_d[c]  = cnt_q[c];
          high_d[c]    = hi_tmp_q[c];
          set_valid[c] = 1'b1;
          set_ovf[c]   = sat[c];
        end else begin
          armed_d[c] = 1'b1;
        end
      end else if (!fall[c] && armed_q[c] && sat[c]) begin
        set_ovf[c] = 1'b1;
      end
    end
    // A set in the same cycle as a software clear takes priority.
    valid_d = set_valid | (valid_q & ~clr);
    ovf_d   = set_ovf   | (ovf_q   & ~clr);
  end

  // Read mux and registered bus response; reads see pre-update state.
  always_comb begin
    rd_word  = '0;
    rvalid_d = bus.device_req_i;
    rdata_d  = '0;
    for (int c = 0; c < CapWidth; c++) begin
      if (chan_hit[c]) begin
        if (!word_sel) begin
          rd_word[BusDataWidth-1]  = valid_q[c];
          rd_word[BusDataWidth-2]  = ovf_q[c];
          rd_word[CapCtrSize-1:0]  = high_q[c];
        end else begin
          rd_word[CapCtrSize-1:0]  = period_q[c];
        end
      end
    end
    if (bus.device_req_i && !bus.device_we_i) rdata_d = rd_word;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      valid_q  <= '0;
      ovf_q    <= '0;
      cnt_q    <= '0;
      hi_tmp_q <= '0;
      high_q   <= '0;
      period_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      armed_q  <= armed_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      hi_tmp_q <= hi_tmp_d;
      high_q   <= high_d;
      period_q <= period_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.device_rvalid_o = rvalid_q;
  assign bus.device_rdata_o  = rdata_q;

endmodule

// File: tb/tb_pwm_capture_wrapper.sv
// Bench for pwm_capture_wrapper: a 4-channel/16-bit instance and a
// 1-channel/8-bit instance for counter saturation. Expected responses are
// queued when a request is issued and compared when rvalid returns.
module tb_pwm_capture_wrapper;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] pwm_a;
  logic [0:0] pwm_b;

  always #5 clk = ~clk;

  pwm_capture_if #(.BusAddrWidth(32), .BusDataWidth(32)) bus_a ();
  pwm_capture_if #(.BusAddrWidth(32), .BusDataWidth(32)) bus_b ();

  pwm_capture_wrapper #(.CapWidth(4), .CapCtrSize(16), .BusAddrWidth(32), .BusDataWidth(32)) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a),
    .pwm_i (pwm_a)
  );

  pwm_capture_wrapper #(.CapWidth(1), .CapCtrSize(8), .BusAddrWidth(32), .BusDataWidth(32)) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b),
    .pwm_i (pwm_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Request seen at each edge, to check the one-cycle response latency.
  logic req_seen_a = 1'b0;
  logic req_seen_b = 1'b0;
  always @(posedge clk) begin
    req_seen_a <= bus_a.device_req_i;
    req_seen_b <= bus_b.device_req_i;
  end

  // Response monitor: compare against the scoreboard away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req_seen_a || bus_a.device_rvalid_o) begin
        check("rvalid_a", 32'(bus_a.device_rvalid_o), 32'(req_seen_a));
        if (bus_a.device_rvalid_o) begin
          if (q_a.size() == 0) check("sb_underflow_a", 32'd1, 32'd0);
          else begin
            e = q_a.pop_front();
            check(e.tag, bus_a.device_rdata_o, e.data);
          end
        end
      end
      if (req_seen_b || bus_b.device_rvalid_o) begin
        check("rvalid_b", 32'(bus_b.device_rvalid_o), 32'(req_seen_b));
        if (bus_b.device_rvalid_o) begin
          if (q_b.size() == 0) check("sb_underflow_b", 32'd1, 32'd0);
          else begin
            e = q_b.pop_front();
            check(e.tag, bus_b.device_rdata_o, e.data);
          end
        end
      end
    end
  end

  // One bus transaction, started on a negedge; writes expect zero rdata.
  task automatic bus_op(input bit sel_b, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag  = tag;
    e.data = we ? 32'h0 : exp;
    if (!sel_b) begin
      bus_a.device_req_i   = 1'b1;
      bus_a.device_we_i    = we;
      bus_a.device_addr_i  = addr;
      bus_a.device_wdata_i = wdata;
      q_a.push_back(e);
    end else begin
      bus_b.device_req_i   = 1'b1;
      bus_b.device_we_i    = we;
      bus_b.device_addr_i  = addr;
      bus_b.device_wdata_i = wdata;
      q_b.push_back(e);
    end
    @(negedge clk);
    bus_a.device_req_i = 1'b0;
    bus_b.device_req_i = 1'b0;
  endtask

  task automatic rd(input bit sel_b, input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus_op(sel_b, 1'b0, addr, 32'h0, exp, tag);
  endtask

  task automatic wr(input bit sel_b, input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    bus_op(sel_b, 1'b1, addr, wdata, 32'h0, tag);
  endtask

  task automatic pwm_run(input int ch, input int period, input int high, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_a[ch] = 1'b1;
      repeat (high) @(negedge clk);
      pwm_a[ch] = 1'b0;
      repeat (period - high) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pwm_a = '0;
    pwm_b = '0;
    bus_a.device_req_i = 1'b0; bus_a.device_we_i = 1'b0; bus_a.device_addr_i = '0;
    bus_a.device_be_i  = 4'hF; bus_a.device_wdata_i = '0;
    bus_b.device_req_i = 1'b0; bus_b.device_we_i = 1'b0; bus_b.device_addr_i = '0;
    bus_b.device_be_i  = 4'hF; bus_b.device_wdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(bus_a.device_rvalid_o), 32'd0);
    check("rst_rdata", bus_a.device_rdata_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    rd(0, 32'h000, 32'h0, "rst_ch0_w0");
    rd(0, 32'h004, 32'h0, "rst_ch0_w1");
    rd(1, 32'h000, 32'h0, "rst_b_w0");

    pwm_run(0, 100, 25, 3);
    repeat (5) @(negedge clk);
    rd(0, 32'h000, 32'h8000_0019, "ch0_w0");
    rd(0, 32'h004, 32'h0000_0064, "ch0_w1");

    fork
      pwm_run(2, 40, 10, 3);
      pwm_run(3, 60, 30, 3);
    join
    repeat (5) @(negedge clk);
    rd(0, 32'h010, 32'h8000_000A, "ch2_w0");
    rd(0, 32'h014, 32'h0000_0028, "ch2_w1");
    rd(0, 32'h018, 32'h8000_001E, "ch3_w0");
    rd(0, 32'h01C, 32'h0000_003C, "ch3_w1");
    rd(0, 32'h008, 32'h0,         "ch1_idle_w0");
    rd(0, 32'h000, 32'h8000_0019, "ch0_after_23");

    wr(0, 32'h000, 32'h1, "w1c");
    rd(0, 32'h000, 32'h0000_0019, "w1c_w0");
    rd(0, 32'h004, 32'h0000_0064, "w1c_w1");

    // Capture at a rise coinciding with a W1C write: valid must survive.
    pwm_run(0, 50, 20, 2);
    pwm_a[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(0, 32'h000, 32'h1, "w1c_race");
    repeat (17) @(negedge clk);
    pwm_a[0] = 1'b0;
    repeat (5) @(negedge clk);
    rd(0, 32'h000, 32'h8000_0014, "race_w0");
    rd(0, 32'h004, 32'h0000_0032, "race_w1");

    wr(0, 32'h000, 32'h0, "w0_bit0_low");
    wr(0, 32'h004, 32'hFFFF_FFFF, "w1_write");
    rd(0, 32'h000, 32'h8000_0014, "noop_w0");
    rd(0, 32'h004, 32'h0000_0032, "noop_w1");

    rd(0, 32'h3F8, 32'h0, "oor_rd");
    wr(0, 32'h3F8, 32'hFFFF_FFFF, "oor_wr");
    rd(0, 32'h000, 32'h8000_0014, "oor_ch0");
    rd(0, 32'h010, 32'h8000_000A, "oor_ch2");

    // 8-bit counter: arm, one high pulse, then stall past saturation.
    pwm_b = 1'b1;
    repeat (10) @(negedge clk);
    pwm_b = 1'b0;
    repeat (300) @(negedge clk);
    rd(1, 32'h000, 32'h4000_0000, "b_stall_w0");
    pwm_b = 1'b1;
    repeat (5) @(negedge clk);
    rd(1, 32'h000, 32'hC000_000A, "b_cap_w0");
    rd(1, 32'h004, 32'h0000_00FF, "b_cap_w1");

    repeat (4) @(negedge clk);
    check("sb_drain_a", 32'(q_a.size()), 32'd0);
    check("sb_drain_b", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
